// File: rtl/pcf8574_lcd_target_if.sv
// rtl/pcf8574_lcd_target_if.sv - I2C bus and decoded LCD signals of the PCF8574/HD44780 target
interface pcf8574_lcd_target_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_out;
    logic [7:0] port;
    logic       backlight;
    logic       busy;
    logic       lcd_valid;
    logic       lcd_rs;
    logic [7:0] lcd_data;
    logic       four_bit;

    modport master (
        output scl_in, sda_in,
        input  sda_out, port, backlight, busy, lcd_valid, lcd_rs, lcd_data, four_bit
    );

    modport slave (
        input  scl_in, sda_in,
        output sda_out, port, backlight, busy, lcd_valid, lcd_rs, lcd_data, four_bit
    );
endinterface

// File: rtl/pcf8574_lcd_target.sv
// rtl/pcf8574_lcd_target.sv - PCF8574 I2C target with HD44780 4/8-bit transfer reassembly
module pcf8574_lcd_target #(
    parameter logic [6:0] ADDR        = 7'h27,
    parameter int         SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    pcf8574_lcd_target_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_WR, ST_WR_ACK, ST_RD, ST_RD_ACK, ST_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_s, sda_s, scl_q, sda_q;
    logic scl_rise, scl_fall, start_det, stop_det;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_in};
            scl_q    <= scl_s;
            sda_q    <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;
    assign start_det = scl_s & scl_q & sda_q & ~sda_s;
    assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

    state_t     state, state_nxt;
    logic [3:0] bit_cnt, cnt_nxt;
    logic [7:0] shreg, sh_nxt;
    logic [7:0] port_r, port_nxt;
    logic       sda_r, sda_nxt;
    logic       busy_r, busy_nxt;
    logic       port_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_cnt <= 4'd0;
            shreg   <= 8'h00;
            port_r  <= 8'hFF;
            sda_r   <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= cnt_nxt;
            shreg   <= sh_nxt;
            port_r  <= port_nxt;
            sda_r   <= sda_nxt;
            busy_r  <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        sh_nxt    = shreg;
        port_nxt  = port_r;
        sda_nxt   = sda_r;
        busy_nxt  = busy_r;
        port_we   = 1'b0;
        if (stop_det) begin
            state_nxt = ST_IDLE;
            sda_nxt   = 1'b1;
            busy_nxt  = 1'b0;
        end else if (start_det) begin
            state_nxt = ST_ADDR;
            cnt_nxt   = 4'd0;
            sda_nxt   = 1'b1;
            busy_nxt  = 1'b0;
        end else begin
            case (state)
                ST_ADDR, ST_WR: begin
                    if (scl_rise && bit_cnt < 4'd8) begin
                        sh_nxt  = {shreg[6:0], sda_s};
                        cnt_nxt = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        cnt_nxt = 4'd0;
                        if (state == ST_WR) begin
                            port_nxt  = shreg;
                            port_we   = 1'b1;
                            sda_nxt   = 1'b0;
                            state_nxt = ST_WR_ACK;
                        end else if (shreg[7:1] == ADDR) begin
                            sda_nxt   = 1'b0;
                            busy_nxt  = 1'b1;
                            state_nxt = ST_ADDR_ACK;
                        end else begin
                            state_nxt = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    // shreg[0] still holds the R/W bit of the address byte
                    if (scl_fall) begin
                        if (shreg[0]) begin
                            sh_nxt    = port_r;
                            sda_nxt   = port_r[7];
                            cnt_nxt   = 4'd1;
                            state_nxt = ST_RD;
                        end else begin
                            sda_nxt   = 1'b1;
                            cnt_nxt   = 4'd0;
                            state_nxt = ST_WR;
                        end
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        sda_nxt   = 1'b1;
                        state_nxt = ST_WR;
                    end
                end
                ST_RD: begin
                    if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_nxt   = 1'b1;
                            cnt_nxt   = 4'd0;
                            state_nxt = ST_RD_ACK;
                        end else begin
                            sda_nxt = shreg[6];
                            sh_nxt  = {shreg[6:0], 1'b1};
                            cnt_nxt = bit_cnt + 4'd1;
                        end
                    end
                end
                ST_RD_ACK: begin
                    // bit_cnt==1 remembers a master ACK until the falling edge lets us drive
                    if (scl_rise) begin
                        if (sda_s) state_nxt = ST_IGNORE;
                        else       cnt_nxt   = 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd1) begin
                        sh_nxt    = port_r;
                        sda_nxt   = port_r[7];
                        state_nxt = ST_RD;
                    end
                end
                default: ;
            endcase
        end
    end

    // E-falling detection uses the pre-write port value; decode runs one clk later
    logic       ev_pend, ev_rs;
    logic [3:0] ev_nib;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ev_pend <= 1'b0;
            ev_rs   <= 1'b0;
            ev_nib  <= 4'h0;
        end else begin
            ev_pend <= port_we & port_r[2] & ~port_nxt[2] & ~port_nxt[1];
            ev_rs   <= port_r[0];
            ev_nib  <= port_r[7:4];
        end
    end

    logic       lcd_valid_r, lcd_rs_r, four_bit_r, phase_high;
    logic [7:0] lcd_data_r;
    logic [3:0] nib_hold;
    logic [7:0] joined;

    assign joined = {nib_hold, ev_nib};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lcd_valid_r <= 1'b0;
            lcd_rs_r    <= 1'b0;
            lcd_data_r  <= 8'h00;
            four_bit_r  <= 1'b0;
            phase_high  <= 1'b1;
            nib_hold    <= 4'h0;
        end else begin
            lcd_valid_r <= 1'b0;
            if (ev_pend) begin
                if (!four_bit_r) begin
                    lcd_valid_r <= 1'b1;
                    lcd_data_r  <= {ev_nib, 4'h0};
                    lcd_rs_r    <= ev_rs;
                    if (!ev_rs && ev_nib == 4'b0010) begin
                        four_bit_r <= 1'b1;
                        phase_high <= 1'b1;
                    end
                end else if (phase_high) begin
                    nib_hold   <= ev_nib;
                    phase_high <= 1'b0;
                end else begin
                    lcd_valid_r <= 1'b1;
                    lcd_data_r  <= joined;
                    lcd_rs_r    <= ev_rs;
                    phase_high  <= 1'b1;
                    if (!ev_rs && joined[7:4] == 4'b0011) four_bit_r <= 1'b0;
                end
            end
        end
    end

    assign bus.sda_out   = sda_r;
    assign bus.port      = port_r;
    assign bus.backlight = port_r[3];
    assign bus.busy      = busy_r;
    assign bus.lcd_valid = lcd_valid_r;
    assign bus.lcd_rs    = lcd_rs_r;
    assign bus.lcd_data  = lcd_data_r;
    assign bus.four_bit  = four_bit_r;
endmodule

// File: tb/tb_pcf8574_lcd_target.sv
// tb/tb_pcf8574_lcd_target.sv - bit-banged I2C master with LCD transfer scoreboard
`timescale 1ns/1ps
module tb_pcf8574_lcd_target;
    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;

    always #5 clk = ~clk;

    pcf8574_lcd_target_if bus();
    assign bus.scl_in = scl_m;
    assign bus.sda_in = sda_m & bus.sda_out;

    pcf8574_lcd_target #(.ADDR(7'h27), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       rs;
        logic [7:0] data;
        logic       fb;
    } lcd_ev_t;

    lcd_ev_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push(input logic rs, input logic [7:0] data, input logic fb);
        lcd_ev_t e;
        e.rs = rs; e.data = data; e.fb = fb;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.lcd_valid) begin
            lcd_ev_t e;
            check("lcd_strobe_expected", sb.size(), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("lcd_data", bus.lcd_data, e.data);
                check("lcd_rs", bus.lcd_rs, e.rs);
                check("four_bit", bus.four_bit, e.fb);
            end
        end
    end

    task automatic hold();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; hold();
        scl_m = 1'b1; hold();
        sda_m = 1'b0; hold();
        scl_m = 1'b0; hold();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; hold();
        scl_m = 1'b1; hold();
        sda_m = 1'b1; hold();
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    hold();
        scl_m = 1'b1; hold(); hold();
        scl_m = 1'b0; hold();
    endtask

    task automatic clock_bit(output logic b);
        sda_m = 1'b1; hold();
        scl_m = 1'b1; hold();
        b = bus.sda_in; hold();
        scl_m = 1'b0; hold();
    endtask

    task automatic wr(input logic [7:0] d, input logic exp_ack, input string tag);
        logic a;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        clock_bit(a);
        check(tag, a, exp_ack);
    endtask

    task automatic rd(input logic nack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) clock_bit(d[i]);
        send_bit(nack);
    endtask

    task automatic drain(input string tag);
        repeat (10) @(posedge clk);
        #1;
        check(tag, sb.size(), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic [7:0] bits;

        repeat (3) @(posedge clk);
        #1;
        check("rst_sda_out", bus.sda_out, 1);
        check("rst_port", bus.port, 8'hFF);
        check("rst_backlight", bus.backlight, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_lcd_valid", bus.lcd_valid, 0);
        check("rst_lcd_rs", bus.lcd_rs, 0);
        check("rst_lcd_data", bus.lcd_data, 8'h00);
        check("rst_four_bit", bus.four_bit, 0);
        rst = 1'b0;
        hold();

        // 8-bit mode: nibble 3 with RS=0
        i2c_start();
        wr(8'h4E, 1'b0, "t1_addr_ack");
        check("t1_busy", bus.busy, 1);
        wr(8'h3C, 1'b0, "t1_d0_ack");
        push(1'b0, 8'h30, 1'b0);
        wr(8'h38, 1'b0, "t1_d1_ack");
        i2c_stop();
        drain("t1_lcd_drained");
        check("t1_port", bus.port, 8'h38);
        check("t1_backlight", bus.backlight, 1);
        check("t1_busy_idle", bus.busy, 0);

        // switch to 4-bit, then one data byte 0x41
        i2c_start();
        wr(8'h4E, 1'b0, "t2_addr_ack");
        wr(8'h2C, 1'b0, "t2_d0_ack");
        push(1'b0, 8'h20, 1'b1);
        wr(8'h28, 1'b0, "t2_d1_ack");
        wr(8'h4D, 1'b0, "t2_d2_ack");
        wr(8'h49, 1'b0, "t2_d3_ack");
        wr(8'h1D, 1'b0, "t2_d4_ack");
        push(1'b1, 8'h41, 1'b1);
        wr(8'h19, 1'b0, "t2_d5_ack");
        i2c_stop();
        drain("t2_lcd_drained");
        check("t2_port", bus.port, 8'h19);

        // read back the port, master NACK
        i2c_start();
        wr(8'h4F, 1'b0, "t3_addr_ack");
        check("t3_busy", bus.busy, 1);
        rd(1'b1, d);
        check("t3_rd_data", d, 8'h19);
        hold();
        check("t3_nack_release", bus.sda_out, 1);
        i2c_stop();

        // foreign address: no ACK, no port change
        i2c_start();
        wr(8'h40, 1'b1, "t4_addr_noack");
        check("t4_busy", bus.busy, 0);
        wr(8'h00, 1'b1, "t4_data_noack");
        i2c_stop();
        check("t4_port", bus.port, 8'h19);

        // 4-bit Function Set with DL=1 returns to 8-bit
        i2c_start();
        wr(8'h4E, 1'b0, "t5_addr_ack");
        wr(8'h3C, 1'b0, "t5_d0_ack");
        wr(8'h38, 1'b0, "t5_d1_ack");
        wr(8'h0C, 1'b0, "t5_d2_ack");
        push(1'b0, 8'h30, 1'b0);
        wr(8'h08, 1'b0, "t5_d3_ack");
        i2c_stop();
        drain("t5_lcd_drained");
        check("t5_port", bus.port, 8'h08);

        // STOP after 5 data bits discards the partial byte
        i2c_start();
        wr(8'h4E, 1'b0, "t6_addr_ack");
        bits = 8'hAA;
        for (int i = 7; i >= 3; i--) send_bit(bits[i]);
        i2c_stop();
        drain("t6_lcd_none");
        check("t6_port", bus.port, 8'h08);
        check("t6_busy", bus.busy, 0);

        // repeated START mid-byte
        i2c_start();
        wr(8'h4E, 1'b0, "t7_addr_ack");
        for (int i = 7; i >= 5; i--) send_bit(bits[i]);
        i2c_start();
        wr(8'h4E, 1'b0, "t7_addr2_ack");
        wr(8'h55, 1'b0, "t7_d0_ack");
        i2c_stop();
        check("t7_port", bus.port, 8'h55);

        // enter 4-bit mode, then reset while the address ACK is driven
        i2c_start();
        wr(8'h4E, 1'b0, "t8_addr_ack");
        wr(8'h2C, 1'b0, "t8_d0_ack");
        push(1'b0, 8'h20, 1'b1);
        wr(8'h28, 1'b0, "t8_d1_ack");
        i2c_stop();
        drain("t8_lcd_drained");
        check("t8_four_bit", bus.four_bit, 1);
        i2c_start();
        bits = 8'h4E;
        for (int i = 7; i >= 0; i--) send_bit(bits[i]);
        sda_m = 1'b1; hold();
        scl_m = 1'b1; hold();
        check("t8_ack_driven", bus.sda_out, 0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t8_rst_sda_async", bus.sda_out, 1);
        @(negedge clk);
        check("t8_rst_port", bus.port, 8'hFF);
        check("t8_rst_four_bit", bus.four_bit, 0);
        check("t8_rst_busy", bus.busy, 0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        hold();
        rst = 1'b0;
        hold();
        drain("end_lcd_drained");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
